// File: rtl/data_memory.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_memory: word-addressed data memory, synchronous write, combinational   |
// | read, asynchronous clear, out-of-range address exception.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module data_memory #(
  parameter int DATA_ADDR_WIDTH = 16,
  parameter int DATA_WIDTH      = 16,
  parameter int DATA_SIZE       = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       write,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       exception
);

  localparam int c_IDX_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  // When DATA_SIZE fills the address space this is all ones and the range check is constant true.
  localparam logic [DATA_ADDR_WIDTH-1:0] c_LAST_ADDR = DATA_ADDR_WIDTH'(DATA_SIZE - 1);

  logic [DATA_WIDTH-1:0] mem_q [DATA_SIZE];
  logic                  w_in_range;
  logic [c_IDX_W-1:0]    w_idx;

  assign w_in_range = (addr <= c_LAST_ADDR);
  assign w_idx      = addr[c_IDX_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else if (write && w_in_range) begin
      mem_q[w_idx] <= data_in;
    end
  end

  assign data_out  = w_in_range ? mem_q[w_idx] : '0;
  assign exception = ~w_in_range;

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_data_memory: randomized and directed self-checking bench for data_memory |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_data_memory;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int DS = 1024;

  logic          clk;
  logic          rst;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic          write;
  logic [DW-1:0] data_out;
  logic          exception;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model [DS];

  data_memory #(
    .DATA_ADDR_WIDTH(AW),
    .DATA_WIDTH     (DW),
    .DATA_SIZE      (DS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_in  (data_in),
    .write    (write),
    .data_out (data_out),
    .exception(exception)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (int'(a) < DS) return model[a[9:0]];
    return '0;
  endfunction

  function automatic logic exp_exc(input logic [AW-1:0] a);
    return int'(a) >= DS;
  endfunction

  task automatic clear_model();
    foreach (model[i]) model[i] = '0;
  endtask

  // Apply inputs mid-cycle, take one rising edge, settle 1 time unit.
  task automatic step(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
    @(negedge clk);
    addr = a; data_in = d; write = w;
    @(posedge clk);
    if (w === 1'b1 && !rst && int'(a) < DS) model[a[9:0]] = d;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; addr = '0; data_in = '0; write = 1'b0;
    #2 rst = 1'b1;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (data_out !== 16'd0) begin bad++; $display("FAIL reset_dout0 got=%h exp=%h", data_out, 16'd0); end
    total++; if (exception !== 1'b0) begin bad++; $display("FAIL reset_exc0 got=%b exp=%b", exception, 1'b0); end
    addr = 16'd1023;
    #1;
    total++; if (data_out !== 16'd0) begin bad++; $display("FAIL reset_dout1023 got=%h exp=%h", data_out, 16'd0); end
    total++; if (exception !== 1'b0) begin bad++; $display("FAIL reset_exc1023 got=%b exp=%b", exception, 1'b0); end
  endtask

  task automatic test_basic_write();
    step(16'd0, 16'd100, 1'b0);
    total++; if (data_out !== 16'd0) begin bad++; $display("FAIL nowrite got=%h exp=%h", data_out, 16'd0); end
    step(16'd0, 16'd100, 1'b1);
    total++; if (data_out !== 16'd100) begin bad++; $display("FAIL write100 got=%h exp=%h", data_out, 16'd100); end
    for (int i = 0; i < 3; i++) begin
      step(16'd0, 16'd55, 1'b0);
      total++; if (data_out !== 16'd100) begin bad++; $display("FAIL hold100 cyc=%0d got=%h exp=%h", i, data_out, 16'd100); end
    end
  endtask

  task automatic test_addressing();
    step(16'd1023, 16'hBEEF, 1'b1);
    step(16'd5, 16'h1234, 1'b1);
    @(negedge clk);
    write = 1'b0; addr = 16'd1023;
    #1;
    total++; if (data_out !== 16'hBEEF) begin bad++; $display("FAIL rd1023 got=%h exp=%h", data_out, 16'hBEEF); end
    total++; if (exception !== 1'b0) begin bad++; $display("FAIL exc1023 got=%b exp=%b", exception, 1'b0); end
    addr = 16'd5;
    #1;
    total++; if (data_out !== 16'h1234) begin bad++; $display("FAIL rd5 got=%h exp=%h", data_out, 16'h1234); end
    addr = 16'd6;
    #1;
    total++; if (data_out !== 16'h0000) begin bad++; $display("FAIL rd6 got=%h exp=%h", data_out, 16'h0000); end
  endtask

  task automatic test_out_of_range();
    step(16'd1024, 16'hFFFF, 1'b1);
    total++; if (exception !== 1'b1) begin bad++; $display("FAIL exc1024 got=%b exp=%b", exception, 1'b1); end
    total++; if (data_out !== 16'h0000) begin bad++; $display("FAIL rd1024 got=%h exp=%h", data_out, 16'h0000); end
    @(negedge clk);
    write = 1'b0; addr = 16'd0;
    #1;
    total++; if (exception !== 1'b0) begin bad++; $display("FAIL exc0_after got=%b exp=%b", exception, 1'b0); end
    total++; if (data_out !== 16'd100) begin bad++; $display("FAIL rd0_after_oor got=%h exp=%h", data_out, 16'd100); end
    addr = 16'hFFFF;
    #1;
    total++; if (exception !== 1'b1) begin bad++; $display("FAIL excFFFF got=%b exp=%b", exception, 1'b1); end
    total++; if (data_out !== 16'h0000) begin bad++; $display("FAIL rdFFFF got=%h exp=%h", data_out, 16'h0000); end
    addr = 16'd1023;
    #1;
    total++; if (data_out !== 16'hBEEF) begin bad++; $display("FAIL rd1023_after_oor got=%h exp=%h", data_out, 16'hBEEF); end
  endtask

  task automatic test_read_during_write();
    @(negedge clk);
    addr = 16'd0; data_in = 16'd200; write = 1'b1;
    #1;
    total++; if (data_out !== 16'd100) begin bad++; $display("FAIL rdw_before got=%h exp=%h", data_out, 16'd100); end
    @(posedge clk);
    model[0] = 16'd200;
    #1;
    total++; if (data_out !== 16'd200) begin bad++; $display("FAIL rdw_after got=%h exp=%h", data_out, 16'd200); end
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic test_write_x();
    step(16'd5, 16'h0099, 1'bx);
    total++; if (data_out !== exp_rd(16'd5)) begin bad++; $display("FAIL write_x got=%h exp=%h", data_out, exp_rd(16'd5)); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    addr = 16'd0; data_in = 16'h4444; write = 1'b1;
    #2 rst = 1'b1;
    clear_model();
    #1;
    total++; if (data_out !== 16'd0) begin bad++; $display("FAIL rstmid_dout got=%h exp=%h", data_out, 16'd0); end
    addr = 16'd1024;
    #1;
    total++; if (exception !== 1'b1) begin bad++; $display("FAIL rstmid_exc got=%b exp=%b", exception, 1'b1); end
    addr = 16'd0;
    @(posedge clk);
    #1;
    total++; if (data_out !== 16'd0) begin bad++; $display("FAIL rst_beats_write got=%h exp=%h", data_out, 16'd0); end
    @(negedge clk);
    rst = 1'b0; write = 1'b0;
    addr = 16'd0;
    #1;
    total++; if (data_out !== 16'd0) begin bad++; $display("FAIL rstmid_rd0 got=%h exp=%h", data_out, 16'd0); end
    addr = 16'd5;
    #1;
    total++; if (data_out !== 16'd0) begin bad++; $display("FAIL rstmid_rd5 got=%h exp=%h", data_out, 16'd0); end
    addr = 16'd1023;
    #1;
    total++; if (data_out !== 16'd0) begin bad++; $display("FAIL rstmid_rd1023 got=%h exp=%h", data_out, 16'd0); end
    step(16'd5, 16'd7, 1'b1);
    total++; if (data_out !== 16'd7) begin bad++; $display("FAIL post_rst_write got=%h exp=%h", data_out, 16'd7); end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          w;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0:       a = AW'($urandom);
        1:       a = AW'($urandom_range(DS - 1, DS));
        default: a = AW'($urandom_range(0, 15));
      endcase
      d = DW'($urandom);
      w = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      addr = a; data_in = d; write = w;
      #1;
      total++; if (data_out !== exp_rd(a)) begin bad++; $display("FAIL rnd_pre i=%0d a=%h got=%h exp=%h", i, a, data_out, exp_rd(a)); end
      total++; if (exception !== exp_exc(a)) begin bad++; $display("FAIL rnd_exc i=%0d a=%h got=%b exp=%b", i, a, exception, exp_exc(a)); end
      @(posedge clk);
      if (w && int'(a) < DS) model[a[9:0]] = d;
      #1;
      total++; if (data_out !== exp_rd(a)) begin bad++; $display("FAIL rnd_post i=%0d a=%h got=%h exp=%h", i, a, data_out, exp_rd(a)); end
      if (i % 97 == 50) begin
        rst = 1'b1;
        clear_model();
        #1;
        total++; if (data_out !== 16'd0) begin bad++; $display("FAIL rnd_rst i=%0d got=%h exp=%h", i, data_out, 16'd0); end
        rst = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_addressing();
    test_out_of_range();
    test_read_during_write();
    test_write_x();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/data_memory.md
Name: data_memory

Overview:
- Word-addressed data memory for the processor's memory stage.
- Writes are synchronous on the clock edge; reads are combinational.
- Reset clears the whole array asynchronously.
- Addresses outside the implemented array raise a combinational exception flag and never modify storage.

Parameters:
- DATA_ADDR_WIDTH, 16, width of the address bus in bits.
- DATA_WIDTH, 16, width of each memory word and of the data buses.
- DATA_SIZE, 1024, number of implemented words; valid addresses are 0 .. DATA_SIZE-1. Must satisfy 1 <= DATA_SIZE <= 2^DATA_ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- rst  input  1  reset; asynchronous, active-high.
- addr  input  DATA_ADDR_WIDTH  word address for both read and write.
- data_in  input  DATA_WIDTH  write data.
- write  input  1  write enable; 1 = store data_in at addr on the next rising clk.
- data_out  output  DATA_WIDTH  read data for addr (combinational).
- exception  output  1  1 when addr is out of range (addr >= DATA_SIZE).

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Port names are clk and rst.
- Storage: DATA_SIZE words of DATA_WIDTH bits. Address is a word index; there is no byte addressing and no alignment check.
- Reset:
  - While rst=1, every word is forced to 0, immediately and independent of clk.
  - Writes are ignored while rst=1.
  - data_out follows the cleared array, i.e. reads 0.
  - exception is still driven purely from addr.
- Write:
  - On a rising clk with rst=0, write=1 and addr < DATA_SIZE: mem[addr] <= data_in.
  - One-cycle latency: the new value is visible on data_out right after that edge.
  - With write=1 and addr >= DATA_SIZE, no location changes.
- Read:
  - data_out = mem[addr] when addr < DATA_SIZE, otherwise all zeros.
  - Purely combinational; changes on addr follow within the same cycle.
- Read-during-write, same address: data_out shows the old contents until the clock edge and the new contents after it. There is no write-through bypass.
- exception:
  - Combinational; exception = (addr >= DATA_SIZE), asserted regardless of write.
  - Not registered and not sticky; deasserts as soon as addr returns in range.
- write=0: memory contents are held indefinitely.
- Boundaries:
  - addr = DATA_SIZE-1 is valid.
  - addr = DATA_SIZE raises exception.
  - If DATA_SIZE = 2^DATA_ADDR_WIDTH, exception is constant 0.
- Unknown/X on write is treated as no write. A simulation warning is permitted.
- Reset asserted mid-operation: the clear wins over any write in the same cycle. After deassertion, the first write occurs on the next qualifying rising edge.
- No other outputs; no handshake. The memory is always ready.

Test Plan:
- Reset: assert rst=1 with addr=0, then release -> data_out=0 and exception=0. Repeat at addr=1023 -> data_out=0.
- Basic write: addr=0, data_in=100, write=0 for one cycle -> data_out stays 0. Set write=1 across one rising edge -> data_out=100. Set write=0, data_in=55 for several cycles -> data_out remains 100.
- Addressing:
  - Write 0xBEEF to addr=1023 and 0x1234 to addr=5.
  - Read back: addr=1023 -> 0xBEEF; addr=5 -> 0x1234; addr=6 -> 0.
  - Changing addr alone updates data_out with no clock edge.
- Out of range: addr=1024, data_in=0xFFFF, write=1 across an edge -> exception=1 and data_out=0. Then addr=0 -> exception=0, and data_out still holds its prior value (100). Also check addr=0xFFFF -> exception=1.
- Read-during-write: addr=0 holding 100, data_in=200, write=1 -> data_out=100 before the edge and 200 after it.
- Reset mid-operation: after the writes above, pulse rst asynchronously between clock edges -> data_out drops to 0 immediately. Then read addr 0, 5 and 1023 -> all 0. Then a write of 7 to addr 5 -> reads 7.
